// File: rtl/spi_frame_fetch.sv
// SPI flash frame fetcher: one read per frame_req, streams FRAME_BITS data bits out of MISO.
// Optional `SPI_FAST_READ_EN: fast-read command 0x0B with 8 dummy SCLK cycles before data.
module spi_frame_fetch #(
  parameter int unsigned           ADDR_WIDTH = 24,
  parameter int unsigned           FRAME_BITS = 768,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           NUM_FRAMES = 4
) (
  input  logic                          CLK_40,
  input  logic                          reset,
  input  logic                          SPI_clk_en,
  input  logic                          frame_req,
  input  logic                          MISO,
  output logic                          SCLK,
  output logic                          CS_n,
  output logic                          MOSI,
  output logic                          bit_valid,
  output logic                          bit_data,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx
);

  localparam int unsigned IDX_W   = $clog2(NUM_FRAMES);
  localparam int unsigned SH_W    = 8 + ADDR_WIDTH;
  localparam int unsigned CNT_MAX = (FRAME_BITS > ADDR_WIDTH) ? FRAME_BITS : ADDR_WIDTH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

  localparam logic [ADDR_WIDTH-1:0] FRAME_BYTES = ADDR_WIDTH'(FRAME_BITS / 8);
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_CMD,
    S_ADDR,
`ifdef SPI_FAST_READ_EN
    S_DUMMY,
`endif
    S_DATA,
    S_CS_HOLD,
    S_FINISH
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [SH_W-1:0]         r_sh;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_sclk;
  logic                    r_csn;
  logic                    r_mosi;
  logic                    r_bv;
  logic                    r_bd;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_last;

  assign w_last = (r_cnt == '0);

  always_ff @(posedge CLK_40) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= BASE_ADDR;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sclk  <= 1'b0;
      r_csn   <= 1'b1;
      r_mosi  <= 1'b0;
      r_bv    <= 1'b0;
      r_bd    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_bv   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // busy is still high during the frame_done cycle; drop it here and ignore any request seen meanwhile
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (frame_req) begin
            r_busy  <= 1'b1;
            r_state <= S_CS_SETUP;
          end
        end

        S_CS_SETUP: begin
          if (SPI_clk_en) begin
            r_csn   <= 1'b0;
            r_mosi  <= CMD_BYTE[7];
            r_sh    <= {CMD_BYTE[6:0], r_addr, 1'b0};
            r_cnt   <= CNT_W'(7);
            r_state <= S_CMD;
          end
        end

        S_CMD, S_ADDR: begin
          if (SPI_clk_en) begin
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
              r_mosi <= r_sh[SH_W-1];
              r_sh   <= {r_sh[SH_W-2:0], 1'b0};
              r_cnt  <= r_cnt - 1'b1;
              if (w_last) begin
                if (r_state == S_CMD) begin
                  r_state <= S_ADDR;
                  r_cnt   <= CNT_W'(ADDR_WIDTH - 1);
                end else begin
                  r_mosi  <= 1'b0;
`ifdef SPI_FAST_READ_EN
                  r_state <= S_DUMMY;
                  r_cnt   <= CNT_W'(7);
`else
                  r_state <= S_DATA;
                  r_cnt   <= CNT_W'(FRAME_BITS - 1);
`endif
                end
              end
            end
          end
        end

`ifdef SPI_FAST_READ_EN
        S_DUMMY: begin
          if (SPI_clk_en) begin
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
              r_cnt <= r_cnt - 1'b1;
              if (w_last) begin
                r_state <= S_DATA;
                r_cnt   <= CNT_W'(FRAME_BITS - 1);
              end
            end
          end
        end
`endif

        S_DATA: begin
          if (SPI_clk_en) begin
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
              r_bd <= MISO;
              r_bv <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
              if (w_last) r_state <= S_CS_HOLD;
            end
          end
        end

        S_CS_HOLD: begin
          if (SPI_clk_en) begin
            r_csn   <= 1'b1;
            r_state <= S_FINISH;
          end
        end

        S_FINISH: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
          if (r_idx == LAST_IDX) begin
            r_idx  <= '0;
            r_addr <= BASE_ADDR;
          end else begin
            r_idx  <= r_idx + 1'b1;
            r_addr <= r_addr + FRAME_BYTES;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SCLK       = r_sclk;
  assign CS_n       = r_csn;
  assign MOSI       = r_mosi;
  assign bit_valid  = r_bv;
  assign bit_data   = r_bd;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign frame_idx  = r_idx;

endmodule

// File: tb/tb_spi_frame_fetch.sv
// Self-checking bench for spi_frame_fetch: flash model, table of frame fetches, directed corner cases.
module tb_spi_frame_fetch;

  localparam int unsigned AW   = 24;
  localparam int unsigned FB   = 768;
  localparam int unsigned NF   = 4;
  localparam logic [23:0] BASE = 24'h000100;
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0]  EXP_CMD = 8'h0B;
  localparam int unsigned HDR     = 40;
`else
  localparam logic [7:0]  EXP_CMD = 8'h03;
  localparam int unsigned HDR     = 32;
`endif
  localparam int unsigned EXP_EN = 2 * (HDR + FB) + 1;

  logic       clk, reset, en, frame_req, miso;
  logic       sclk, cs_n, mosi, bit_valid, bit_data, busy, frame_done;
  logic [1:0] frame_idx;

  spi_frame_fetch #(
    .ADDR_WIDTH (AW),
    .FRAME_BITS (FB),
    .BASE_ADDR  (BASE),
    .NUM_FRAMES (NF)
  ) dut (
    .CLK_40     (clk),
    .reset      (reset),
    .SPI_clk_en (en),
    .frame_req  (frame_req),
    .MISO       (miso),
    .SCLK       (sclk),
    .CS_n       (cs_n),
    .MOSI       (mosi),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_idx  (frame_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Enable pacing: periodic, or manual pulses through en_force when en_period is 0.
  int unsigned en_period = 2;
  logic        en_force  = 1'b0;
  initial begin
    int unsigned div;
    div = 0;
    en  = 1'b0;
    forever begin
      @(negedge clk);
      if (en_period == 0) begin
        en = en_force;
      end else begin
        div++;
        if (div >= en_period) begin
          en  = 1'b1;
          div = 0;
        end else begin
          en = 1'b0;
        end
      end
    end
  end

  function automatic logic patbit(input logic [7:0] p, input int unsigned k);
    return p[7 - (k % 8)];
  endfunction

  // Flash model and bus monitor; per-frame counters clear when CS_n falls.
  logic [7:0]  pat_byte = 8'hA5;
  logic [31:0] hdr_cap;
  int unsigned rises, en_cnt, bv_cnt, bit_err, mosi_bad;
  int unsigned done_cnt = 0;
  int unsigned sclk_bad = 0;
  initial begin
    logic prev_sclk, prev_csn;
    prev_sclk = 1'b0;
    prev_csn  = 1'b1;
    hdr_cap = '0; rises = 0; en_cnt = 0; bv_cnt = 0; bit_err = 0; mosi_bad = 0;
    miso = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (cs_n !== prev_csn) begin
        if (reset === 1'b1 && sclk !== 1'b0) sclk_bad++;
        rises = 0;
        if (cs_n === 1'b0) begin
          en_cnt = 0; bv_cnt = 0; bit_err = 0; mosi_bad = 0; hdr_cap = '0;
        end
      end
      if (cs_n === 1'b0 && en === 1'b1) en_cnt++;
      if (!prev_sclk && sclk === 1'b1 && cs_n === 1'b0) begin
        if (rises < 32) hdr_cap = {hdr_cap[30:0], mosi};
        else if (mosi !== 1'b0) mosi_bad++;
        rises++;
      end
      if (bit_valid === 1'b1) begin
        if (bit_data !== patbit(pat_byte, bv_cnt)) bit_err++;
        bv_cnt++;
      end
      if (frame_done === 1'b1) done_cnt++;
      miso = (cs_n === 1'b0 && rises >= HDR) ? patbit(pat_byte, rises - HDR) : 1'b1;
      prev_sclk = sclk;
      prev_csn  = cs_n;
    end
  end

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, what, act, exp);
    end
  endtask

  task automatic start_frame(input string tag, input logic [7:0] pat, input logic [1:0] exp_idx);
    pat_byte = pat;
    @(negedge clk) frame_req = 1'b1;
    @(negedge clk) frame_req = 1'b0;
    chk(tag, "busy after req", 32'(busy), 32'd1);
    chk(tag, "frame_idx during fetch", 32'(frame_idx), 32'(exp_idx));
  endtask

  task automatic finish_frame(input string tag, input logic [1:0] exp_idx_next, input int unsigned done0);
    int unsigned t;
    t = 0;
    while (frame_done !== 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, "frame_done seen", 32'(frame_done), 32'd1);
    chk(tag, "busy at frame_done", 32'(busy), 32'd1);
    chk(tag, "CS_n at frame_done", 32'(cs_n), 32'd1);
    chk(tag, "frame_idx after", 32'(frame_idx), 32'(exp_idx_next));
    @(negedge clk);
    chk(tag, "busy/done cleared", 32'({busy, frame_done}), 32'd0);
    repeat (6) @(negedge clk);
    chk(tag, "frame_done count", done_cnt - done0, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [23:0] exp_addr);
    chk(tag, "cmd+addr on MOSI", hdr_cap, {EXP_CMD, exp_addr});
    chk(tag, "bit_valid count", bv_cnt, FB);
    chk(tag, "bit_data errors", bit_err, 32'd0);
    chk(tag, "en pulses with CS_n low", en_cnt, EXP_EN);
    chk(tag, "MOSI nonzero after addr", mosi_bad, 32'd0);
  endtask

  task automatic wait_bits(input string tag, input int unsigned n);
    int unsigned t;
    t = 0;
    while (cs_n !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    while (bv_cnt < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, "bit_valid target reached", 32'(bv_cnt >= n), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  pat;
    logic [23:0] addr;
    logic [1:0]  idx;
    logic [1:0]  idx_next;
    int unsigned period;
  } vec_t;

  vec_t        tbl [5];
  int unsigned d0;

  initial begin
    tbl[0] = '{8'hA5, 24'h000100, 2'd0, 2'd1, 4};
    tbl[1] = '{8'h3C, 24'h000160, 2'd1, 2'd2, 2};
    tbl[2] = '{8'hF0, 24'h0001C0, 2'd2, 2'd3, 3};
    tbl[3] = '{8'h69, 24'h000220, 2'd3, 2'd0, 2};
    tbl[4] = '{8'hA5, 24'h000100, 2'd0, 2'd1, 2};

    reset     = 1'b0;
    frame_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", "outputs {SCLK,CS_n,MOSI,bv,bd,busy,done,idx}",
        32'({sclk, cs_n, mosi, bit_valid, bit_data, busy, frame_done, frame_idx}),
        32'(9'b0_1_0_0_0_0_0_00));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      @(posedge clk) #1 en_period = tbl[i].period;
      @(negedge clk);
      d0 = done_cnt;
      start_frame($sformatf("fetch%0d", i), tbl[i].pat, tbl[i].idx);
      finish_frame($sformatf("fetch%0d", i), tbl[i].idx_next, d0);
      check_frame($sformatf("fetch%0d", i), tbl[i].addr);
    end

    // Request while busy mid-DATA must not queue a second fetch.
    d0 = done_cnt;
    start_frame("busyreq", 8'h55, 2'd1);
    wait_bits("busyreq", 200);
    frame_req = 1'b1;
    @(negedge clk) frame_req = 1'b0;
    finish_frame("busyreq", 2'd2, d0);
    check_frame("busyreq", 24'h000160);
    repeat (20) @(negedge clk);
    chk("busyreq", "still idle later", 32'({busy, cs_n}), 32'b01);

    // Enable coinciding with frame_req is not the CS_SETUP pulse.
    @(posedge clk) #1 begin en_period = 0; en_force = 1'b0; end
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    pat_byte = 8'hC3;
    @(posedge clk) #1 en_force = 1'b1;
    @(negedge clk) frame_req = 1'b1;
    @(posedge clk) #1 en_force = 1'b0;
    @(negedge clk) frame_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("coincide", "CS_n still high", 32'(cs_n), 32'd1);
    chk("coincide", "busy waiting", 32'(busy), 32'd1);
    @(posedge clk) #1 en_force = 1'b1;
    @(posedge clk) #1 en_force = 1'b0;
    @(negedge clk);
    chk("coincide", "CS_n low after one en", 32'({cs_n, sclk}), 32'd0);
    @(posedge clk) #1 en_period = 2;
    finish_frame("coincide", 2'd3, d0);
    check_frame("coincide", 24'h0001C0);

    // Reset mid-DATA aborts and rewinds the address.
    d0 = done_cnt;
    start_frame("abort", 8'h96, 2'd3);
    wait_bits("abort", 100);
    reset = 1'b0;
    @(negedge clk);
    chk("abort", "CS_n high next cycle", 32'(cs_n), 32'd1);
    chk("abort", "busy/SCLK/idx after reset", 32'({busy, sclk, frame_idx}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort", "no frame_done", done_cnt - d0, 32'd0);

    d0 = done_cnt;
    start_frame("postabort", 8'hA5, 2'd0);
    finish_frame("postabort", 2'd1, d0);
    check_frame("postabort", BASE);

    chk("global", "SCLK high at CS_n change", sclk_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
